vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Generates VGA raster timing for the jml-8-mini-vga peripheral: horizontal/vertical counters, sync pulses and blanking.
- Sits directly upstream of the pixel generator.
- Supplies the current column, the current line and the next line's index, so the pixel generator can prefetch the next line's glyph rows into its line buffer one line ahead.
- Also emits a one-cycle frame_start pulse for the video RAM / CPU interface.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, horizontal back porch in clocks
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync
- CBITS, 10, width of counter outputs; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- horicount  out  CBITS  current column, 0..H_TOTAL-1
- vertcount  out  CBITS  current line, 0..V_TOTAL-1
- nextline  out  CBITS  line after vertcount, wraps to 0
- visible  out  1  current (horicount, vertcount) is in the active area
- prefetch  out  1  horicount<H_VISIBLE and nextline<V_VISIBLE
- hsync  out  1  horizontal sync, level per HSYNC_POL
- vsync  out  1  vertical sync, level per VSYNC_POL
- frame_start  out  1  one-cycle pulse on the first pixel of a frame

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800).
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 525).
- Reset values (while rst_n=0, asynchronously):
  - horicount=0, vertcount=0, nextline=1.
  - visible=0, prefetch=0, frame_start=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- Two-state FSM:
  - ARM (reset state) → RUN on the first rising clk edge with rst_n=1.
  - On that edge the counters stay at 0,0, and all outputs take their decoded values for (0,0): visible=1, prefetch=1, frame_start=1.
  - RUN holds until reset.
- Counter rules in RUN, each edge:
  - horicount increments.
  - At H_TOTAL-1 it wraps to 0 and vertcount increments.
  - vertcount wraps V_TOTAL-1 → 0 on the same edge that horicount wraps.
  - nextline = vertcount+1, or 0 when vertcount=V_TOTAL-1.
  - All arithmetic is modulo CBITS width; counters never exceed TOTAL-1.
- Output decode:
  - All outputs are registered.
  - Each decode is computed from the next-state counter values, so every output is consistent with the horicount/vertcount presented in the same cycle (zero relative latency, no combinational paths to outputs).
  - visible = (h<H_VISIBLE) && (v<V_VISIBLE).
  - prefetch = (h<H_VISIBLE) && (nextline<V_VISIBLE). It is high during the active columns of line V_TOTAL-1 (prefetching line 0), and low on line V_VISIBLE-1 (next line is blank).
  - hsync is active when H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
  - vsync is active when V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC (default 490..491) and is asserted for whole lines (changes only at h=0).
  - frame_start = (h==0 && v==0). It is exactly one cycle wide, once per H_TOTAL*V_TOTAL clocks.
- Reset mid-frame: all outputs return to reset values immediately. The FSM returns to ARM, and the next frame starts cleanly at (0,0) with frame_start.
- No other inputs; the raster never stalls.

Test Plan:
- Release rst_n → on the first edge horicount=0, vertcount=0, nextline=1, visible=1, prefetch=1, frame_start=1. On the second edge horicount=1 and frame_start=0.
- Run one line → horicount reaches 799 then 0, and vertcount goes 0→1 on that same edge. visible is high for exactly 640 cycles. hsync is low exactly for h=656..751 (96 cycles).
- Run a full frame (420000 clocks) → frame_start pulses exactly once, period 420000. vsync is low for exactly 1600 clocks, vertcount=490..491, and transitions only when h=0.
- Line 479 → nextline=480 and prefetch stays 0. Line 524 → nextline=0 and prefetch=1 for h=0..639, while visible=0.
- Assert rst_n low at h=300, v=200 → outputs go to reset values without waiting for clk. After release, the frame restarts at (0,0) with frame_start=1.
- Parameter override H_VISIBLE=8, H_FRONT=1, H_SYNC=2, H_BACK=1, V_VISIBLE=4, V_FRONT=1, V_SYNC=1, V_BACK=1, HSYNC_POL=1 → H_TOTAL=12 and V_TOTAL=7 wrap correctly. hsync is high for h=9..10.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running column/line counters with registered
// sync, blanking, next-line prefetch and frame-start strobes aligned to the counters.
module vga_timing #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0,
  parameter int unsigned CBITS     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CBITS-1:0] horicount,
  output logic [CBITS-1:0] vertcount,
  output logic [CBITS-1:0] nextline,
  output logic             visible,
  output logic             prefetch,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CBITS-1:0] ONE_C      = CBITS'(1'b1);
  localparam logic [CBITS-1:0] H_LAST_C   = CBITS'(H_TOTAL - 1);
  localparam logic [CBITS-1:0] V_LAST_C   = CBITS'(V_TOTAL - 1);
  localparam logic [CBITS-1:0] H_VIS_C    = CBITS'(H_VISIBLE);
  localparam logic [CBITS-1:0] V_VIS_C    = CBITS'(V_VISIBLE);
  localparam logic [CBITS-1:0] HS_START_C = CBITS'(H_VISIBLE + H_FRONT);
  localparam logic [CBITS-1:0] HS_END_C   = CBITS'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CBITS-1:0] VS_START_C = CBITS'(V_VISIBLE + V_FRONT);
  localparam logic [CBITS-1:0] VS_END_C   = CBITS'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [0:0] {
    ARM = 1'b0,
    RUN = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CBITS-1:0] h_r, v_r, nl_r;
  logic [CBITS-1:0] h_nxt_s, v_nxt_s, nl_nxt_s;
  logic             visible_r, prefetch_r, hsync_r, vsync_r, frame_start_r;
  logic             visible_nxt_s, prefetch_nxt_s, hsync_nxt_s, vsync_nxt_s, frame_start_nxt_s;

  // Next raster position and its decoded outputs; outputs are decoded from the
  // next-state counters so they register in the same cycle as the counters.
  always_comb begin
    state_nxt_s = state_r;
    h_nxt_s     = h_r;
    v_nxt_s     = v_r;
    case (state_r)
      ARM: begin
        state_nxt_s = RUN;
        h_nxt_s     = '0;
        v_nxt_s     = '0;
      end
      RUN: begin
        if (h_r == H_LAST_C) begin
          h_nxt_s = '0;
          if (v_r == V_LAST_C) begin
            v_nxt_s = '0;
          end else begin
            v_nxt_s = v_r + ONE_C;
          end
        end else begin
          h_nxt_s = h_r + ONE_C;
        end
      end
      default: begin
        state_nxt_s = ARM;
        h_nxt_s     = '0;
        v_nxt_s     = '0;
      end
    endcase

    nl_nxt_s          = (v_nxt_s == V_LAST_C) ? '0 : v_nxt_s + ONE_C;
    visible_nxt_s     = (h_nxt_s < H_VIS_C) && (v_nxt_s < V_VIS_C);
    prefetch_nxt_s    = (h_nxt_s < H_VIS_C) && (nl_nxt_s < V_VIS_C);
    hsync_nxt_s       = ((h_nxt_s >= HS_START_C) && (h_nxt_s < HS_END_C)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_nxt_s       = ((v_nxt_s >= VS_START_C) && (v_nxt_s < VS_END_C)) ? VSYNC_POL : ~VSYNC_POL;
    frame_start_nxt_s = (h_nxt_s == '0) && (v_nxt_s == '0);
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ARM;
      h_r           <= '0;
      v_r           <= '0;
      nl_r          <= ONE_C;
      visible_r     <= 1'b0;
      prefetch_r    <= 1'b0;
      hsync_r       <= ~HSYNC_POL;
      vsync_r       <= ~VSYNC_POL;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      h_r           <= h_nxt_s;
      v_r           <= v_nxt_s;
      nl_r          <= nl_nxt_s;
      visible_r     <= visible_nxt_s;
      prefetch_r    <= prefetch_nxt_s;
      hsync_r       <= hsync_nxt_s;
      vsync_r       <= vsync_nxt_s;
      frame_start_r <= frame_start_nxt_s;
    end
  end

  assign horicount   = h_r;
  assign vertcount   = v_r;
  assign nextline    = nl_r;
  assign visible     = visible_r;
  assign prefetch    = prefetch_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default and reduced-size instances checked every cycle
// against an index-based raster model, plus checkpoint tables and corner sequences.
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] nl;
    logic       vis;
    logic       pre;
    logic       hs;
    logic       vs;
    logic       fs;
  } obs_t;

  typedef struct packed {
    obs_t d;
    obs_t s;
  } pair_t;

  typedef struct {
    int   cyc;
    obs_t e;
  } vec_t;

  logic clk;
  logic rst_n_d, rst_n_s;
  logic [9:0] horicount_d, vertcount_d, nextline_d;
  logic       visible_d, prefetch_d, hsync_d, vsync_d, frame_start_d;
  logic [9:0] horicount_s, vertcount_s, nextline_s;
  logic       visible_s, prefetch_s, hsync_s, vsync_s, frame_start_s;

  int    errors, checks;
  int    n_d, n_s;
  int    vis_cnt, hsl_cnt, vsl_cnt, fs_cnt, last_fs;
  logic  prev_vs, prev_vs_ok;
  pair_t q[$];
  vec_t  vecs[$];

  vga_timing dut_d (
    .clk(clk), .rst_n(rst_n_d),
    .horicount(horicount_d), .vertcount(vertcount_d), .nextline(nextline_d),
    .visible(visible_d), .prefetch(prefetch_d), .hsync(hsync_d), .vsync(vsync_d),
    .frame_start(frame_start_d)
  );

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CBITS(10)
  ) dut_s (
    .clk(clk), .rst_n(rst_n_s),
    .horicount(horicount_s), .vertcount(vertcount_s), .nextline(nextline_s),
    .visible(visible_s), .prefetch(prefetch_s), .hsync(hsync_s), .vsync(vsync_s),
    .frame_start(frame_start_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input int h, input int v, input int nl,
                              input logic vis, input logic pre, input logic hs,
                              input logic vs, input logic fs);
    obs_t o;
    o.h = 10'(h); o.v = 10'(v); o.nl = 10'(nl);
    o.vis = vis; o.pre = pre; o.hs = hs; o.vs = vs; o.fs = fs;
    return o;
  endfunction

  // Raster position derived from the clock index since release, not from counters.
  function automatic obs_t model(input int n, input int hv, input int hf, input int hsw,
                                 input int hb, input int vv, input int vf, input int vsw,
                                 input int vb, input logic hpol, input logic vpol);
    int ht, vt, pos, h, v, nl;
    logic hact, vact;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (n < 0) return mk(0, 0, 1, 1'b0, 1'b0, ~hpol, ~vpol, 1'b0);
    pos  = n % (ht * vt);
    h    = pos % ht;
    v    = pos / ht;
    nl   = (v + 1) % vt;
    hact = (h >= hv + hf) && (h < hv + hf + hsw);
    vact = (v >= vv + vf) && (v < vv + vf + vsw);
    return mk(h, v, nl, (h < hv) && (v < vv), (h < hv) && (nl < vv),
              hact ? hpol : ~hpol, vact ? vpol : ~vpol, pos == 0);
  endfunction

  function automatic obs_t obs_d();
    return {horicount_d, vertcount_d, nextline_d, visible_d, prefetch_d, hsync_d, vsync_d, frame_start_d};
  endfunction

  function automatic obs_t obs_s();
    return {horicount_s, vertcount_s, nextline_s, visible_s, prefetch_s, hsync_s, vsync_s, frame_start_s};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got h=%0d v=%0d nl=%0d vis/pre/hs/vs/fs=%b%b%b%b%b, expected h=%0d v=%0d nl=%0d vis/pre/hs/vs/fs=%b%b%b%b%b",
               name, act.h, act.v, act.nl, act.vis, act.pre, act.hs, act.vs, act.fs,
               exp.h, exp.v, exp.nl, exp.vis, exp.pre, exp.hs, exp.vs, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int cyc, input obs_t e);
    vec_t t;
    t.cyc = cyc;
    t.e   = e;
    vecs.push_back(t);
  endtask

  // One clock: model predicts at the edge, DUT outputs are compared at the falling edge.
  task automatic tick();
    pair_t p;
    @(posedge clk);
    n_d = rst_n_d ? n_d + 1 : -1;
    n_s = rst_n_s ? n_s + 1 : -1;
    p.d = model(n_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    p.s = model(n_s, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b0);
    q.push_back(p);
    @(negedge clk);
    p = q.pop_front();
    check("dflt_cycle", obs_d(), p.d);
    check("small_cycle", obs_s(), p.s);
    if (n_d >= 0 && n_d < 800) begin
      vis_cnt += int'(visible_d);
      hsl_cnt += int'(!hsync_d);
    end
    if (n_s >= 0) begin
      if (prev_vs_ok && (vsync_s !== prev_vs)) check_int("small_vsync_edge_h", int'(horicount_s), 0);
      prev_vs    = vsync_s;
      prev_vs_ok = 1'b1;
      if (frame_start_s) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          check_int("small_fs_period", n_s - last_fs, 84);
          check_int("small_vsync_low_clks", vsl_cnt, 12);
        end
        last_fs = n_s;
        vsl_cnt = 0;
      end
      vsl_cnt += int'(!vsync_s);
    end else begin
      prev_vs_ok = 1'b0;
      last_fs    = -1;
      vsl_cnt    = 0;
    end
  endtask

  task automatic seek_small(input int target);
    int guard;
    guard = 0;
    while ((n_s % 84) != target && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      errors++;
      checks++;
      $display("FAIL seek_small: position %0d not reached, at %0d", target, n_s);
    end
  endtask

  initial begin
    int guard;
    errors = 0; checks = 0; n_d = -1; n_s = -1;
    vis_cnt = 0; hsl_cnt = 0; vsl_cnt = 0; fs_cnt = 0; last_fs = -1;
    prev_vs = 1'b1; prev_vs_ok = 1'b0;
    rst_n_d = 1'b1; rst_n_s = 1'b1;

    // Default-instance checkpoints: clock index after release and expected outputs.
    add_vec(0,    mk(0,   0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    add_vec(1,    mk(1,   0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    add_vec(639,  mk(639, 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    add_vec(640,  mk(640, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    add_vec(655,  mk(655, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    add_vec(656,  mk(656, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec(751,  mk(751, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    add_vec(752,  mk(752, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    add_vec(799,  mk(799, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    add_vec(800,  mk(0,   1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    add_vec(1600, mk(0,   2, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));

    #1;
    rst_n_d = 1'b0; rst_n_s = 1'b0;
    #2;
    check("reset_dflt", obs_d(), mk(0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    check("reset_small", obs_s(), mk(0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    repeat (2) tick();
    rst_n_d = 1'b1; rst_n_s = 1'b1;

    foreach (vecs[i]) begin
      guard = 0;
      while (n_d < vecs[i].cyc && guard < 4000) begin
        tick();
        guard++;
      end
      check_int("vec_cycle_reached", n_d, vecs[i].cyc);
      check($sformatf("vec_n%0d", vecs[i].cyc), obs_d(), vecs[i].e);
    end
    check_int("line0_visible_clks", vis_cnt, 640);
    check_int("line0_hsync_low_clks", hsl_cnt, 96);
    check_int("small_fs_pulses", fs_cnt, 20);

    // Reduced raster corners: last visible line, hsync window, vsync line, wrap line.
    seek_small(38);
    check("small_line3", obs_s(), mk(2, 3, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    seek_small(45);
    check("small_hsync_h9", obs_s(), mk(9, 3, 4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tick();
    check("small_hsync_h10", obs_s(), mk(10, 3, 4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tick();
    check("small_hsync_h11", obs_s(), mk(11, 3, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    seek_small(60);
    check("small_vsync_line", obs_s(), mk(0, 5, 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    seek_small(74);
    check("small_last_line", obs_s(), mk(2, 6, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    tick();
    check("small_last_line_h3", obs_s(), mk(3, 6, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));

    // Mid-frame reset must take effect without a clock edge, then restart cleanly.
    seek_small(27);
    rst_n_d = 1'b0; rst_n_s = 1'b0;
    #1;
    check("midframe_reset_dflt", obs_d(), mk(0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    check("midframe_reset_small", obs_s(), mk(0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    repeat (2) tick();
    rst_n_d = 1'b1; rst_n_s = 1'b1;
    tick();
    check("restart_dflt", obs_d(), mk(0, 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    check("restart_small", obs_s(), mk(0, 0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    tick();
    check("restart_dflt_h1", obs_d(), mk(1, 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    fs_cnt = 0;
    repeat (170) tick();
    check_int("small_fs_pulses_after_restart", fs_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
